// File: rtl/bram_arbiter.sv
// bram_arbiter: two requesters share one single-port BRAM (1-cycle registered read).
// Grants are round-robin by default; define BRAM_ARB_FIXED_PRIO_EN for fixed priority (A wins ties).
module bram_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_i_data,
    output logic                  ram_w_e,
    output logic                  ram_r_e,
    input  logic [DATA_WIDTH-1:0] ram_o_data
);

    logic                  infl_a_q, infl_a_d;
    logic                  infl_b_q, infl_b_d;
    logic                  rsp_valid_a_q, rsp_valid_a_d;
    logic                  rsp_valid_b_q, rsp_valid_b_d;
    logic [DATA_WIDTH-1:0] rsp_data_a_q, rsp_data_a_d;
    logic [DATA_WIDTH-1:0] rsp_data_b_q, rsp_data_b_d;
    logic                  elig_a, elig_b;
    logic                  grant_a, grant_b;
`ifndef BRAM_ARB_FIXED_PRIO_EN
    logic                  rr_b_q, rr_b_d;
`endif

    // A port stays blocked from its read grant until the cycle after its response handshake.
    always_comb begin
        elig_a = a_req_valid & ~infl_a_q & ~rsp_valid_a_q;
        elig_b = b_req_valid & ~infl_b_q & ~rsp_valid_b_q;
`ifdef BRAM_ARB_FIXED_PRIO_EN
        grant_a = elig_a & ~reset;
`else
        grant_a = elig_a & (~elig_b | ~rr_b_q) & ~reset;
`endif
        grant_b = elig_b & ~grant_a & ~reset;
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    // With no grant the RAM address/data default to port A's fields.
    assign ram_addr   = grant_b ? b_req_addr  : a_req_addr;
    assign ram_i_data = grant_b ? b_req_wdata : a_req_wdata;
    assign ram_w_e    = (grant_a & a_req_we)  | (grant_b & b_req_we);
    assign ram_r_e    = (grant_a & ~a_req_we) | (grant_b & ~b_req_we);

    always_comb begin
        infl_a_d      = grant_a & ~a_req_we;
        infl_b_d      = grant_b & ~b_req_we;
        rsp_valid_a_d = rsp_valid_a_q;
        rsp_data_a_d  = rsp_data_a_q;
        rsp_valid_b_d = rsp_valid_b_q;
        rsp_data_b_d  = rsp_data_b_q;
        if (infl_a_q) begin
            rsp_valid_a_d = 1'b1;
            rsp_data_a_d  = ram_o_data;
        end else if (rsp_valid_a_q & a_rsp_ready) begin
            rsp_valid_a_d = 1'b0;
        end
        if (infl_b_q) begin
            rsp_valid_b_d = 1'b1;
            rsp_data_b_d  = ram_o_data;
        end else if (rsp_valid_b_q & b_rsp_ready) begin
            rsp_valid_b_d = 1'b0;
        end
    end

`ifndef BRAM_ARB_FIXED_PRIO_EN
    // Pointer names the port that wins the next tie: always the one just passed over.
    always_comb begin
        rr_b_d = rr_b_q;
        if (grant_a) begin
            rr_b_d = 1'b1;
        end else if (grant_b) begin
            rr_b_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_b_q <= 1'b0;
        end else begin
            rr_b_q <= rr_b_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            infl_a_q      <= 1'b0;
            infl_b_q      <= 1'b0;
            rsp_valid_a_q <= 1'b0;
            rsp_valid_b_q <= 1'b0;
            rsp_data_a_q  <= '0;
            rsp_data_b_q  <= '0;
        end else begin
            infl_a_q      <= infl_a_d;
            infl_b_q      <= infl_b_d;
            rsp_valid_a_q <= rsp_valid_a_d;
            rsp_valid_b_q <= rsp_valid_b_d;
            rsp_data_a_q  <= rsp_data_a_d;
            rsp_data_b_q  <= rsp_data_b_d;
        end
    end

    assign a_rsp_valid = rsp_valid_a_q;
    assign a_rsp_data  = rsp_data_a_q;
    assign b_rsp_valid = rsp_valid_b_q;
    assign b_rsp_data  = rsp_data_b_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed scenarios plus randomized traffic against a transaction-level model
// of the arbiter and a behavioural single-port RAM.
module tb_bram_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
    logic [8:0]   a_req_addr;
    logic [127:0] a_req_wdata, a_rsp_data;
    logic         b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
    logic [8:0]   b_req_addr;
    logic [127:0] b_req_wdata, b_rsp_data;
    logic [8:0]   ram_addr;
    logic [127:0] ram_i_data, ram_o_data;
    logic         ram_w_e, ram_r_e;

    int n_vec = 0;
    int n_err = 0;
    bit run = 1'b0;

    bram_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(128)) dut (
        .clk(clk), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
        .ram_addr(ram_addr), .ram_i_data(ram_i_data), .ram_w_e(ram_w_e), .ram_r_e(ram_r_e),
        .ram_o_data(ram_o_data)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] init_pat(input logic [8:0] a);
        return {4{23'h5A5A5A, a}};
    endfunction

    // Behavioural RAM: registered read, o_data held on writes and idle cycles.
    logic [127:0] ram [0:511];
    bit           ram_wr [0:511];
    always @(posedge clk) begin
        if (ram_w_e) begin
            ram[ram_addr]    <= ram_i_data;
            ram_wr[ram_addr] <= 1'b1;
        end
        if (ram_r_e) ram_o_data <= ram_wr[ram_addr] ? ram[ram_addr] : init_pat(ram_addr);
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: each port owns at most one outstanding read, busy from grant
    // until its response is consumed; ties go to whichever port was not served last.
    bit           m_outa, m_outb, m_pa, m_pb, m_va, m_vb, m_prefa;
    logic [127:0] m_da, m_db, m_rda, m_rdb;
    logic [127:0] m_mem [0:511];
    bit           m_wr [0:511];

    always @(negedge clk) begin : model
        bit ea, eb, ga, gb;
        if (run) begin
            if (reset) begin
                m_outa = 0; m_outb = 0; m_pa = 0; m_pb = 0; m_va = 0; m_vb = 0;
                m_da = '0; m_db = '0; m_prefa = 1;
            end
            ea = !reset && a_req_valid && !m_outa;
            eb = !reset && b_req_valid && !m_outb;
`ifdef BRAM_ARB_FIXED_PRIO_EN
            ga = ea;
`else
            ga = ea && (!eb || m_prefa);
`endif
            gb = eb && !ga;
            chk1("a_req_ready", a_req_ready, ga);
            chk1("b_req_ready", b_req_ready, gb);
            chk1("ram_w_e", ram_w_e, (ga && a_req_we) || (gb && b_req_we));
            chk1("ram_r_e", ram_r_e, (ga && !a_req_we) || (gb && !b_req_we));
            chkw("ram_addr", 128'(ram_addr), gb ? 128'(b_req_addr) : 128'(a_req_addr));
            chkw("ram_i_data", ram_i_data, gb ? b_req_wdata : a_req_wdata);
            chk1("a_rsp_valid", a_rsp_valid, m_va);
            chkw("a_rsp_data", a_rsp_data, m_da);
            chk1("b_rsp_valid", b_rsp_valid, m_vb);
            chkw("b_rsp_data", b_rsp_data, m_db);
            if (!reset) begin
                if (m_va && a_rsp_ready) begin m_va = 0; m_outa = 0; end
                if (m_vb && b_rsp_ready) begin m_vb = 0; m_outb = 0; end
                if (m_pa) begin m_pa = 0; m_va = 1; m_da = m_rda; end
                if (m_pb) begin m_pb = 0; m_vb = 1; m_db = m_rdb; end
                if (ga) begin
                    if (a_req_we) begin
                        m_mem[a_req_addr] = a_req_wdata; m_wr[a_req_addr] = 1;
                    end else begin
                        m_outa = 1; m_pa = 1;
                        m_rda = m_wr[a_req_addr] ? m_mem[a_req_addr] : init_pat(a_req_addr);
                    end
                    m_prefa = 0;
                end
                if (gb) begin
                    if (b_req_we) begin
                        m_mem[b_req_addr] = b_req_wdata; m_wr[b_req_addr] = 1;
                    end else begin
                        m_outb = 1; m_pb = 1;
                        m_rdb = m_wr[b_req_addr] ? m_mem[b_req_addr] : init_pat(b_req_addr);
                    end
                    m_prefa = 1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit   a_hold, b_hold;
        byte  seq [$];
        int   alt_bad;
        reset = 1; run = 1;
        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1;
        repeat (2) cyc();
        reset = 0;
        @(negedge clk);
        chk1("rst a_rsp_valid", a_rsp_valid, 1'b0);
        chkw("rst a_rsp_data", a_rsp_data, '0);

        // A writes A5.. at address 3, then reads it back with a stalled response channel
        cyc(); a_req_valid = 1; a_req_we = 1; a_req_addr = 3; a_req_wdata = {16{8'hA5}};
        @(negedge clk);
        chk1("wr a_req_ready", a_req_ready, 1'b1);
        chk1("wr ram_w_e", ram_w_e, 1'b1);
        chkw("wr ram_addr", 128'(ram_addr), 128'd3);
        cyc(); a_req_we = 0;
        @(negedge clk);
        chk1("rd a_req_ready", a_req_ready, 1'b1);
        chk1("rd ram_r_e", ram_r_e, 1'b1);
        cyc(); a_req_addr = 5;
        @(negedge clk);
        chk1("rd T+1 a_rsp_valid", a_rsp_valid, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk);
            chk1("hold a_rsp_valid", a_rsp_valid, 1'b1);
            chkw("hold a_rsp_data", a_rsp_data, {16{8'hA5}});
            chk1("hold a_req_ready", a_req_ready, 1'b0);
        end
        cyc(); a_rsp_ready = 1;
        @(negedge clk);
        chk1("hs a_req_ready", a_req_ready, 1'b0);
        cyc();
        @(negedge clk);
        chk1("post-hs a_rsp_valid", a_rsp_valid, 1'b0);
        chk1("post-hs a_req_ready", a_req_ready, 1'b1);
        cyc(); a_req_valid = 0;
        repeat (3) cyc();

        // Idle: no RAM activity, no grants
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge clk);
            chk1("idle ram_w_e", ram_w_e, 1'b0);
            chk1("idle ram_r_e", ram_r_e, 1'b0);
            chk1("idle rdy", a_req_ready | b_req_ready, 1'b0);
        end

        // Both request reads continuously; last grant was A so B wins the first tie
        cyc(); a_req_valid = 1; a_req_addr = 0; b_req_valid = 1; b_req_we = 0; b_req_addr = 1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            if (a_req_ready) seq.push_back(8'd65);
            if (b_req_ready) seq.push_back(8'd66);
        end
        chkw("tie grant count", 128'(seq.size()), 128'd6);
`ifdef BRAM_ARB_FIXED_PRIO_EN
        chkw("tie first grant", 128'(seq[0]), 128'd65);
`else
        chkw("tie first grant", 128'(seq[0]), 128'd66);
`endif
        alt_bad = 0;
        for (int i = 1; i < seq.size(); i++) if (seq[i] == seq[i-1]) alt_bad++;
        chkw("tie alternation", 128'(alt_bad), 128'd0);
        cyc(); a_req_valid = 0; b_req_valid = 0;
        repeat (4) cyc();

        // Read of addr 7 by A, then B overwrites it the next cycle
        a_req_valid = 1; a_req_we = 1; a_req_addr = 7; a_req_wdata = {16{8'h11}};
        @(negedge clk);
        chk1("t4 a wr grant", a_req_ready, 1'b1);
        cyc(); a_req_we = 0;
        @(negedge clk);
        chk1("t4 a rd grant", a_req_ready, 1'b1);
        cyc(); a_req_valid = 0;
        b_req_valid = 1; b_req_we = 1; b_req_addr = 7; b_req_wdata = {16{8'h22}};
        @(negedge clk);
        chk1("t4 b wr grant", b_req_ready, 1'b1);
        cyc(); b_req_valid = 0;
        @(negedge clk);
        chk1("t4 a_rsp_valid", a_rsp_valid, 1'b1);
        chkw("t4 a_rsp_data", a_rsp_data, {16{8'h11}});
        cyc(); b_req_valid = 1; b_req_we = 0;
        @(negedge clk);
        chk1("t4 b rd grant", b_req_ready, 1'b1);
        cyc(); b_req_valid = 0;
        cyc();
        @(negedge clk);
        chk1("t4 b_rsp_valid", b_rsp_valid, 1'b1);
        chkw("t4 b_rsp_data", b_rsp_data, {16{8'h22}});
        repeat (2) cyc();

        // Reset in the cycle after an A read grant discards that read
        a_req_valid = 1; a_req_we = 0; a_req_addr = 2;
        @(negedge clk);
        chk1("t5 a grant", a_req_ready, 1'b1);
        cyc(); reset = 1; b_req_valid = 1; b_req_we = 0; b_req_addr = 4;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            chk1("t5 rst ram_r_e", ram_r_e, 1'b0);
            chk1("t5 rst ram_w_e", ram_w_e, 1'b0);
            chk1("t5 rst a_rsp_valid", a_rsp_valid, 1'b0);
            chk1("t5 rst rdy", a_req_ready | b_req_ready, 1'b0);
        end
        cyc(); reset = 0;
        @(negedge clk);
        chk1("t5 post a grant", a_req_ready, 1'b1);
        chk1("t5 post b grant", b_req_ready, 1'b0);
        cyc(); a_req_valid = 0;
        @(negedge clk);
        cyc(); b_req_valid = 0;
        repeat (3) cyc();

        // Randomized traffic, honouring the hold-while-not-ready rule
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a_hold = a_req_valid && !a_req_ready && !reset;
            b_hold = b_req_valid && !b_req_ready && !reset;
            cyc();
            if (reset) reset = 0;
            else if ($urandom_range(0, 399) == 0) reset = 1;
            if (!a_hold) begin
                a_req_valid = ($urandom_range(0, 2) != 0);
                a_req_we    = $urandom_range(0, 1) != 0;
                a_req_addr  = 9'($urandom_range(0, 7));
                a_req_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!b_hold) begin
                b_req_valid = ($urandom_range(0, 2) != 0);
                b_req_we    = $urandom_range(0, 1) != 0;
                b_req_addr  = 9'($urandom_range(0, 7));
                b_req_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            a_rsp_ready = ($urandom_range(0, 3) != 0);
            b_rsp_ready = ($urandom_range(0, 3) != 0);
        end
        cyc(); a_req_valid = 0; b_req_valid = 0; reset = 0; a_rsp_ready = 1; b_rsp_ready = 1;
        repeat (5) cyc();
        run = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
